// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and op-classification helpers.
package mdu_pkg;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CALC   = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   // Ops whose operands are two's complement and need magnitude/sign handling.
   function automatic logic is_signed(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // Ops that fold the product into the existing HI/LO pair.
   function automatic logic is_acc(input logic [3:0] op);
      return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

   function automatic logic is_sub(input logic [3:0] op);
      return (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

   // Ops that run through the multi-cycle datapath; codes 11-15 fall out here.
   function automatic logic is_arith(input logic [3:0] op);
      return (op != OP_NONE) && (op <= OP_MSUBU) && (op != OP_MTHI) && (op != OP_MTLO);
   endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface mdu_iter_if #(
   parameter int WIDTH = 32
);
   logic             i_start;
   logic [3:0]       i_op;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] o_hi;
   logic [WIDTH-1:0] o_lo;

   modport master (
      output i_start, i_op, i_a, i_b,
      input  o_busy, o_done, o_hi, o_lo
   );

   modport slave (
      input  i_start, i_op, i_a, i_b,
      output o_busy, o_done, o_hi, o_lo
   );
endinterface

// File: rtl/mdu_iter_core.sv
// Per-iteration datapath: one radix-2 shift-add multiply step or one
// restoring divide step per cycle on an unsigned 2*WIDTH partial register.
// Multiply: partial = {acc, multiplier}, shifted right each step.
// Divide:   partial = {remainder, dividend/quotient}, shifted left each step.
module mdu_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic               div_mode,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic [2*WIDTH-1:0] part
);

   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   p_hi;
   logic [WIDTH-1:0]   p_lo;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] part_nxt;

   assign p_hi = part[2*WIDTH-1:WIDTH];
   assign p_lo = part[WIDTH-1:0];

   // Next partial value for either the multiply or the divide iteration.
   always_comb begin
      mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      div_trial = {p_hi, p_lo[WIDTH-1]};
      div_diff  = div_trial - {1'b0, b_q};
      // Remainder stays below the divisor, so the top bit of the difference is the borrow.
      div_ge    = ~div_diff[WIDTH];
      if (div_mode) begin
         part_nxt = {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                     p_lo[WIDTH-2:0], div_ge};
      end else begin
         part_nxt = {mul_sum, p_lo[WIDTH-1:1]};
      end
   end

   // Partial and operand-B registers: loaded on accept, stepped during CALC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         part <= '0;
         b_q  <= '0;
      end else if (load) begin
         part <= {{WIDTH{1'b0}}, a_in};
         b_q  <= b_in;
      end else if (step) begin
         part <= part_nxt;
      end
   end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit holding HI/LO. Arithmetic ops take WIDTH
// CALC cycles plus one FINISH cycle; MTHI/MTLO write in zero busy cycles.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       reset,
   mdu_iter_if.slave  bus
);

   localparam int CW = $clog2(WIDTH);

   state_t             state;
   state_t             state_nxt;
   logic [CW-1:0]      count;
   logic [3:0]         op_q;
   logic               neg_main;
   logic               neg_rem;
   logic               b_zero;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic               done;
   logic               busy;
   logic               accept;
   logic               last;
   logic               sgn_in;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [2*WIDTH-1:0] part;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] res;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;

   assign accept = (state == ST_IDLE) && bus.i_start && is_arith(bus.i_op);
   assign last   = (count == CW'(WIDTH - 1));
   assign sgn_in = is_signed(bus.i_op);
   assign a_mag  = (sgn_in && bus.i_a[WIDTH-1]) ? -bus.i_a : bus.i_a;
   assign b_mag  = (sgn_in && bus.i_b[WIDTH-1]) ? -bus.i_b : bus.i_b;

   mdu_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .step     (state == ST_CALC),
      .div_mode (is_div(op_q)),
      .a_in     (a_mag),
      .b_in     (b_mag),
      .part     (part)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // FSM next-state and busy flag.
   always_comb begin
      state_nxt = state;
      busy      = (state != ST_IDLE);
      case (state)
         ST_IDLE:   if (accept) state_nxt = ST_CALC;
         ST_CALC:   if (last)   state_nxt = ST_FINISH;
         ST_FINISH: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Op latch, sign flags and iteration counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q     <= OP_NONE;
         neg_main <= 1'b0;
         neg_rem  <= 1'b0;
         b_zero   <= 1'b0;
         count    <= '0;
      end else if (accept) begin
         op_q     <= bus.i_op;
         neg_main <= sgn_in & (bus.i_a[WIDTH-1] ^ bus.i_b[WIDTH-1]);
         neg_rem  <= sgn_in & bus.i_a[WIDTH-1];
         b_zero   <= (bus.i_b == '0);
         count    <= '0;
      end else if ((state == ST_CALC) && !last) begin
         count <= count + 1'b1;
      end
   end

   // Sign fix-up and accumulation of the finished magnitude result.
   always_comb begin
      acc  = {hi, lo};
      prod = neg_main ? -part : part;
      quot = neg_main ? -part[WIDTH-1:0] : part[WIDTH-1:0];
      rem  = neg_rem ? -part[2*WIDTH-1:WIDTH] : part[2*WIDTH-1:WIDTH];
      res  = acc;
      if (is_div(op_q)) begin
         // Divide by zero leaves HI/LO untouched.
         if (!b_zero) res = {rem, quot};
      end else if (is_acc(op_q)) begin
         res = is_sub(op_q) ? (acc - prod) : (acc + prod);
      end else begin
         res = prod;
      end
   end

   // HI/LO: arithmetic result on leaving FINISH, direct moves while idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (state == ST_FINISH) begin
         {hi, lo} <= res;
      end else if ((state == ST_IDLE) && bus.i_start) begin
         if (bus.i_op == OP_MTHI)      hi <= bus.i_a;
         else if (bus.i_op == OP_MTLO) lo <= bus.i_a;
      end
   end

   // Completion pulse for the cycle after HI/LO take a result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) done <= 1'b0;
      else       done <= (state == ST_FINISH);
   end

   assign bus.o_busy = busy;
   assign bus.o_done = done;
   assign bus.o_hi   = hi;
   assign bus.o_lo   = lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: cycle-level behavioural model plus
// directed literal checks and randomized operation sequences.
module tb_mdu_iter;

   localparam int WIDTH = 32;

   logic clk;
   logic reset;
   logic chk_en;
   int   n_checks;
   int   n_errors;

   mdu_iter_if #(.WIDTH(WIDTH)) bus ();

   mdu_iter #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result of an op, computed with plain wide arithmetic.
   function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                input logic [31:0] b, input logic [63:0] acc);
      logic [63:0] ps;
      logic [63:0] pu;
      int sa;
      int sb;
      sa = a;
      sb = b;
      ps = 64'(longint'(sa) * longint'(sb));
      pu = {32'b0, a} * {32'b0, b};
      case (op)
         4'd1:  return ps;
         4'd2:  return pu;
         4'd7:  return acc + ps;
         4'd8:  return acc + pu;
         4'd9:  return acc - ps;
         4'd10: return acc - pu;
         4'd3: begin
            if (b == 32'd0) return acc;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            return {32'(sa % sb), 32'(sa / sb)};
         end
         4'd4: begin
            if (b == 32'd0) return acc;
            return {a % b, a / b};
         end
         default: return acc;
      endcase
   endfunction

   // Model state: cycles of busy remaining, pending op and architectural HI/LO.
   int          m_rem;
   logic        m_done;
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic [3:0]  m_op;
   logic [31:0] m_a;
   logic [31:0] m_b;

   // Behavioural model: an accepted op occupies WIDTH+1 edges, result lands on the last.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_rem  <= 0;
         m_done <= 1'b0;
         m_hi   <= '0;
         m_lo   <= '0;
         m_op   <= '0;
         m_a    <= '0;
         m_b    <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_rem > 1) begin
            m_rem <= m_rem - 1;
         end else if (m_rem == 1) begin
            m_rem          <= 0;
            {m_hi, m_lo}   <= model_result(m_op, m_a, m_b, {m_hi, m_lo});
            m_done         <= 1'b1;
         end else if (bus.i_start) begin
            if (bus.i_op == 4'd5)      m_hi <= bus.i_a;
            else if (bus.i_op == 4'd6) m_lo <= bus.i_a;
            else if (bus.i_op >= 4'd1 && bus.i_op <= 4'd10) begin
               m_op  <= bus.i_op;
               m_a   <= bus.i_a;
               m_b   <= bus.i_b;
               m_rem <= WIDTH + 1;
            end
         end
      end
   end

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", {63'd0, bus.o_busy}, {63'd0, (m_rem != 0)});
         check("done", {63'd0, bus.o_done}, {63'd0, m_done});
         check("hi", {32'd0, bus.o_hi}, {32'd0, m_hi});
         check("lo", {32'd0, bus.o_lo}, {32'd0, m_lo});
      end
   end

   // Issue one request at a falling edge and follow it until the unit is idle again.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int nbusy, output int ndone);
      bus.i_op    = op;
      bus.i_a     = a;
      bus.i_b     = b;
      bus.i_start = 1'b1;
      nbusy = 0;
      ndone = 0;
      @(negedge clk);
      bus.i_start = 1'b0;
      for (int k = 0; k < WIDTH + 8; k++) begin
         if (bus.o_busy) nbusy++;
         if (bus.o_done) ndone++;
         if (!bus.o_busy) break;
         @(negedge clk);
      end
      if (bus.o_busy) check("idle_timeout", 64'd1, 64'd0);
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] corner [5];
      corner[0] = 32'h0;
      corner[1] = 32'h1;
      corner[2] = 32'hFFFF_FFFF;
      corner[3] = 32'h8000_0000;
      corner[4] = 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
      if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 20)) - 32'd10;
      return $urandom;
   endfunction

   initial begin
      int nb;
      int nd;
      logic [3:0] rop;
      n_checks    = 0;
      n_errors    = 0;
      chk_en      = 1'b0;
      reset       = 1'b1;
      bus.i_start = 1'b0;
      bus.i_op    = '0;
      bus.i_a     = '0;
      bus.i_b     = '0;
      repeat (3) @(negedge clk);
      reset  = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);

      // Reset state
      check("rst_busy", {63'd0, bus.o_busy}, 64'd0);
      check("rst_done", {63'd0, bus.o_done}, 64'd0);
      check("rst_hilo", {bus.o_hi, bus.o_lo}, 64'd0);

      // Signed multiply with latency/pulse accounting
      run_op(4'd1, 32'hFFFF_FFFD, 32'd5, nb, nd);
      check("mult_hilo", {bus.o_hi, bus.o_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
      check("mult_busy_cycles", 64'(nb), 64'd33);
      check("mult_done_pulses", 64'(nd), 64'd1);

      // Back-to-back: issued in the done cycle
      run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, nd);
      check("multu_hilo", {bus.o_hi, bus.o_lo}, 64'hFFFF_FFFE_0000_0001);

      run_op(4'd3, 32'hFFFF_FFF9, 32'd2, nb, nd);
      check("div_neg", {bus.o_hi, bus.o_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(4'd4, 32'd7, 32'd2, nb, nd);
      check("divu", {bus.o_hi, bus.o_lo}, 64'h0000_0001_0000_0003);
      run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb, nd);
      check("div_min_m1", {bus.o_hi, bus.o_lo}, 64'h0000_0000_8000_0000);

      // Moves and accumulate/subtract
      run_op(4'd5, 32'd0, 32'd0, nb, nd);
      check("mthi_busy", 64'(nb), 64'd0);
      run_op(4'd6, 32'h10, 32'd0, nb, nd);
      check("mtlo_busy", 64'(nb), 64'd0);
      check("mtlo_val", {32'd0, bus.o_lo}, 64'h10);
      run_op(4'd7, 32'd2, 32'd3, nb, nd);
      check("madd", {bus.o_hi, bus.o_lo}, 64'h0000_0000_0000_0016);
      run_op(4'd9, 32'd4, 32'd8, nb, nd);
      check("msub", {bus.o_hi, bus.o_lo}, 64'hFFFF_FFFF_FFFF_FFF6);

      // Divide by zero, with requests arriving while busy
      run_op(4'd5, 32'hA, 32'd0, nb, nd);
      run_op(4'd6, 32'hB, 32'd0, nb, nd);
      bus.i_op = 4'd4; bus.i_a = 32'd9; bus.i_b = 32'd0; bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      nb = 1;
      nd = 0;
      repeat (4) @(negedge clk);
      nb += 4;
      bus.i_op = 4'd5; bus.i_a = 32'h55; bus.i_start = 1'b1;
      @(negedge clk);
      nb++;
      bus.i_op = 4'd1; bus.i_a = 32'd3; bus.i_b = 32'd3;
      @(negedge clk);
      nb++;
      bus.i_start = 1'b0;
      for (int k = 0; k < WIDTH + 8; k++) begin
         @(negedge clk);
         if (bus.o_done) nd++;
         if (!bus.o_busy) break;
         nb++;
      end
      check("div0_hilo", {bus.o_hi, bus.o_lo}, 64'h0000_000A_0000_000B);
      check("div0_busy_cycles", 64'(nb), 64'd33);
      check("div0_done", 64'(nd), 64'd1);

      // Reset in the middle of CALC
      bus.i_op = 4'd1; bus.i_a = 32'd100; bus.i_b = 32'd100; bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_busy", {63'd0, bus.o_busy}, 64'd0);
      check("midrst_done", {63'd0, bus.o_done}, 64'd0);
      check("midrst_hilo", {bus.o_hi, bus.o_lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      nd = 0;
      for (int k = 0; k < WIDTH + 8; k++) begin
         @(negedge clk);
         if (bus.o_done) nd++;
      end
      check("midrst_no_done", 64'(nd), 64'd0);
      run_op(4'd1, 32'd6, 32'd7, nb, nd);
      check("mult_after_rst", {bus.o_hi, bus.o_lo}, 64'd42);

      // Randomized sequences, including undefined codes and back-to-back issue
      for (int n = 0; n < 150; n++) begin
         rop = 4'($urandom_range(0, 15));
         run_op(rop, pick_operand(), pick_operand(), nb, nd);
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
